// File: rtl/odd_seq_checker_pkg.sv
// Shared types and defaults for the odd-sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package odd_seq_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_LOSS_CNT = 3;
    localparam int DEF_ERR_W    = 8;

    // Stride of the upstream odd counter.
    localparam int CNT_STEP     = 2;

endpackage

// File: rtl/odd_seq_checker_if.sv
// Sample stream in, lock/error status out, for the odd-sequence checker.
// Latency: n/a (wiring only).
// Backpressure: none; en_i only qualifies samples, the checker never stalls.
interface odd_seq_checker_if
    import odd_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ERR_W = DEF_ERR_W
);
    logic             en_i;
    logic [WIDTH-1:0] cnt_i;
    logic             locked_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;
    logic             wrap_o;

    // Producer side: the counter (or a bench) driving samples.
    modport master (
        output en_i, cnt_i,
        input  locked_o, err_o, err_cnt_o, wrap_o
    );

    // Checker side.
    modport slave (
        input  en_i, cnt_i,
        output locked_o, err_o, err_cnt_o, wrap_o
    );
endinterface

// File: rtl/odd_seq_checker_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Latency: 1 cycle from inc to updated count.
// Backpressure: none; increments beyond saturation are dropped.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold once every bit is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/odd_seq_checker.sv
// Locks onto the +2 odd count stream, flags breaks, tallies errors, marks wraps.
// Latency: 1 cycle from qualified sample to registered outputs.
// Backpressure: none; samples with en_i low are ignored and all state holds.
module odd_seq_checker
    import odd_seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic               clk,
    input  logic               rst,
    odd_seq_checker_if.slave   bus
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(LOSS_CNT + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [MC_W-1:0]  match_q, match_d;
    logic [MS_W-1:0]  miss_q, miss_d;
    logic             locked_q;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] expected;
    logic             hit;
    logic             odd;
    logic [ERR_W-1:0] err_cnt;

    // Modulo-2^WIDTH prediction: FF+2 naturally lands on 01.
    assign expected = prev_q + WIDTH'(CNT_STEP);
    assign hit      = (bus.cnt_i == expected);
    assign odd      = bus.cnt_i[0];

    // Next-state, register updates and pulse outputs for each qualified sample.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        if (bus.en_i) begin
            case (state_q)
                SEARCH: begin
                    if (odd) begin
                        prev_d  = bus.cnt_i;
                        match_d = '0;
                        state_d = LOCKING;
                    end
                end
                LOCKING: begin
                    if (hit) begin
                        prev_d  = bus.cnt_i;
                        match_d = match_q + MC_W'(1);
                        if (match_q == MC_W'(LOCK_CNT - 1)) begin
                            miss_d  = '0;
                            state_d = LOCKED;
                        end
                    end else if (odd) begin
                        // Plausible odd value: restart the run from here.
                        prev_d  = bus.cnt_i;
                        match_d = '0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        prev_d = bus.cnt_i;
                        miss_d = '0;
                        wrap_d = (bus.cnt_i == WIDTH'(1));
                    end else begin
                        // Keep predicting so an isolated glitch costs one error.
                        prev_d = expected;
                        err_d  = 1'b1;
                        miss_d = miss_q + MS_W'(1);
                        if (miss_q == MS_W'(LOSS_CNT - 1)) begin
                            state_d = SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // State, tracking registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= SEARCH;
            prev_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= (state_d == LOCKED);
            err_q    <= err_d;
            wrap_q   <= wrap_d;
        end
    end

    // Error tally survives lock loss; only reset clears it.
    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (err_d),
        .cnt (err_cnt)
    );

    assign bus.locked_o  = locked_q;
    assign bus.err_o     = err_q;
    assign bus.wrap_o    = wrap_q;
    assign bus.err_cnt_o = err_cnt;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed-vector bench for odd_seq_checker.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_odd_seq_checker;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [7:0] p;

    odd_seq_checker_if #(.WIDTH(8), .ERR_W(8)) bus ();

    odd_seq_checker #(
        .WIDTH    (8),
        .LOCK_CNT (4),
        .LOSS_CNT (3),
        .ERR_W    (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one sample on the falling edge, then let outputs settle after the rising edge.
    task automatic step(input logic en, input int v);
        @(negedge clk);
        bus.en_i  = en;
        bus.cnt_i = 8'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.en_i  = 1'b0;
        bus.cnt_i = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset, then feed five consecutive odd values ending at 'last'.
    task automatic lock_at(input int last);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, last - 8 + 2 * k);
            chk("lock_err", bus.err_o, 0);
            if (k == 3) chk("pre_lock", bus.locked_o, 0);
        end
        chk("lock", bus.locked_o, 1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.en_i     = 1'b0;
        bus.cnt_i    = 8'd0;

        // Reset state
        do_reset();
        chk("rst_locked", bus.locked_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_wrap", bus.wrap_o, 0);
        chk("rst_errcnt", bus.err_cnt_o, 0);

        // 1..9 locks after the fourth +2 step
        lock_at(9);
        chk("t1_errcnt", bus.err_cnt_o, 0);

        // Wrap 255 -> 1 while locked
        lock_at(249);
        step(1'b1, 251); chk("t2_wrap251", bus.wrap_o, 0);
        step(1'b1, 253); chk("t2_wrap253", bus.wrap_o, 0);
        step(1'b1, 255); chk("t2_wrap255", bus.wrap_o, 0);
        step(1'b1, 1);
        chk("t2_wrap1", bus.wrap_o, 1);
        chk("t2_err1", bus.err_o, 0);
        chk("t2_lock1", bus.locked_o, 1);
        step(1'b1, 3);
        chk("t2_wrap3", bus.wrap_o, 0);
        chk("t2_lock3", bus.locked_o, 1);

        // Single glitch absorbed by prediction
        lock_at(21);
        step(1'b1, 40);
        chk("t3_err40", bus.err_o, 1);
        chk("t3_cnt40", bus.err_cnt_o, 1);
        chk("t3_lock40", bus.locked_o, 1);
        step(1'b1, 25);
        chk("t3_err25", bus.err_o, 0);
        chk("t3_lock25", bus.locked_o, 1);
        step(1'b1, 27);
        chk("t3_err27", bus.err_o, 0);
        chk("t3_cnt27", bus.err_cnt_o, 1);

        // Two misses (one short of loss) then a match on the prediction 33
        step(1'b1, 0); chk("t3b_err_a", bus.err_o, 1);
        step(1'b1, 0); chk("t3b_err_b", bus.err_o, 1);
        chk("t3b_lock_b", bus.locked_o, 1);
        step(1'b1, 33);
        chk("t3b_err33", bus.err_o, 0);
        chk("t3b_lock33", bus.locked_o, 1);
        chk("t3b_cnt33", bus.err_cnt_o, 3);

        // Three misses drop lock, relock keeps the tally
        lock_at(9);
        step(1'b1, 100); chk("t4_err1", bus.err_o, 1); chk("t4_lock1", bus.locked_o, 1);
        step(1'b1, 100); chk("t4_err2", bus.err_o, 1); chk("t4_lock2", bus.locked_o, 1);
        step(1'b1, 100); chk("t4_err3", bus.err_o, 1); chk("t4_lock3", bus.locked_o, 0);
        chk("t4_cnt3", bus.err_cnt_o, 3);
        step(1'b1, 1);   chk("t4_noerr_search", bus.err_o, 0);
        step(1'b1, 3);
        step(1'b1, 5);
        step(1'b1, 7);   chk("t4_prelock", bus.locked_o, 0);
        step(1'b1, 9);   chk("t4_relock", bus.locked_o, 1);
        chk("t4_cnt_hold", bus.err_cnt_o, 3);
        // Upstream restart (jump to 1) is just a mismatch
        step(1'b1, 1);
        chk("t4_up_err", bus.err_o, 1);
        chk("t4_up_cnt", bus.err_cnt_o, 4);
        chk("t4_up_wrap", bus.wrap_o, 0);

        // en_i low holds everything
        lock_at(9);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 50);
            chk("t5_err_idle", bus.err_o, 0);
            chk("t5_lock_idle", bus.locked_o, 1);
        end
        step(1'b1, 11);
        chk("t5_err11", bus.err_o, 0);
        chk("t5_lock11", bus.locked_o, 1);
        chk("t5_cnt11", bus.err_cnt_o, 0);

        // Even stream never leaves SEARCH
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 2 * k);
            chk("t6_even_lock", bus.locked_o, 0);
            chk("t6_even_err", bus.err_o, 0);
        end
        chk("t6_even_cnt", bus.err_cnt_o, 0);

        // LOCKING: odd mismatch re-seeds the run
        do_reset();
        step(1'b1, 1);
        step(1'b1, 3);
        step(1'b1, 11);
        step(1'b1, 13);
        step(1'b1, 15);
        step(1'b1, 17);  chk("reseed_pre", bus.locked_o, 0);
        step(1'b1, 19);  chk("reseed_lock", bus.locked_o, 1);
        chk("reseed_cnt", bus.err_cnt_o, 0);

        // LOCKING: even mismatch falls back to SEARCH
        do_reset();
        step(1'b1, 1);
        step(1'b1, 3);
        step(1'b1, 6);
        step(1'b1, 8);
        step(1'b1, 10);
        chk("even_drop_lock", bus.locked_o, 0);
        chk("even_drop_err", bus.err_o, 0);

        // Error tally saturates at 255
        lock_at(9);
        p = 8'd9;
        for (int k = 0; k < 255; k++) begin
            step(1'b1, 0);
            p = p + 8'd2;
            step(1'b1, int'(p + 8'd2));
            p = p + 8'd2;
        end
        chk("sat_cnt255", bus.err_cnt_o, 255);
        chk("sat_lock", bus.locked_o, 1);
        step(1'b1, 0);
        chk("sat_err", bus.err_o, 1);
        chk("sat_hold", bus.err_cnt_o, 255);

        // Async reset mid-LOCKED clears outputs before the next edge
        #1;
        rst = 1'b1;
        #1;
        chk("arst_locked", bus.locked_o, 0);
        chk("arst_err", bus.err_o, 0);
        chk("arst_wrap", bus.wrap_o, 0);
        chk("arst_cnt", bus.err_cnt_o, 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
